// File: rtl/bmu_pkg.sv
// Shared types for the BMU writeback path.
// BMU_RD_W       : destination register tag width
// bmu_wb_entry_t : one queued writeback {rd, data, err}
package bmu_pkg;

  localparam int unsigned BMU_RD_W = 5;

  typedef struct packed {
    logic [BMU_RD_W-1:0] rd;
    logic [31:0]         data;
    logic                err;
  } bmu_wb_entry_t;

endpackage

// File: rtl/bmu_wb_fifo.sv
// Generic synchronous FIFO of bmu_wb_entry_t.
// Ports:
//   clk, rst_l : clock, asynchronous active-low reset
//   flush_i    : synchronous discard of all contents (beats push/pop)
//   push_i     : write wdata_i (dropped when full unless popping too)
//   pop_i      : retire head entry (ignored when empty)
//   wdata_i    : entry to write
//   rdata_o    : head entry, all-zero when empty
//   full_o     : count == DEPTH
//   empty_o    : count == 0
//   count_o    : entries held
module bmu_wb_fifo
  import bmu_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic          clk,
  input  logic          rst_l,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  bmu_wb_entry_t wdata_i,
  output bmu_wb_entry_t rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  bmu_wb_entry_t    mem_q [DEPTH];

  logic do_push;
  logic do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop) & ~flush_i;

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: reads are masked to zero while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/bmu_wb_queue.sv
// Writeback queue behind the BMU: pairs each issued destination tag with the
// BMU result one cycle later, buffers the entries and drains them to the
// register-file write port.
// Ports:
//   clk, rst_l          : clock, asynchronous active-low reset
//   valid_in, rd_in     : op issued to the BMU this cycle and its tag
//   result_in, error_in : BMU registered result/error (belongs to last cycle's op)
//   flush               : discard queue and the in-flight op
//   err_clr             : clear err_count
//   stall_out           : upstream must not issue while high
//   wb_valid/ready      : head-entry handshake; wb_rd/data/error carry the head
//   count               : entries held
//   err_count           : saturating count of accepted entries with error set
//   overflow            : sticky, an entry was dropped because the queue was full
module bmu_wb_queue
  import bmu_pkg::*;
#(
  parameter  int unsigned DEPTH     = 4,
  parameter  int unsigned RD_W      = BMU_RD_W,
  parameter  int unsigned ERR_CNT_W = 8,
  localparam int unsigned CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic                 valid_in,
  input  logic [RD_W-1:0]      rd_in,
  input  logic [31:0]          result_in,
  input  logic                 error_in,
  input  logic                 flush,
  input  logic                 err_clr,
  output logic                 stall_out,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [RD_W-1:0]      wb_rd,
  output logic [31:0]          wb_data,
  output logic                 wb_error,
  output logic [CNT_W-1:0]     count,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 overflow
);

  logic                 s1_valid_q, s1_valid_d;
  logic [RD_W-1:0]      s1_rd_q, s1_rd_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 overflow_q, overflow_d;

  logic          push, pop, accept, drop;
  logic          fifo_full, fifo_empty;
  bmu_wb_entry_t wr_entry, head;

  assign push   = s1_valid_q & ~flush;
  assign pop    = wb_valid & wb_ready & ~flush;
  assign accept = push & (~fifo_full | pop);
  assign drop   = push & fifo_full & ~pop;

  assign wr_entry = '{rd: s1_rd_q, data: result_in, err: error_in};

  bmu_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_l   (rst_l),
    .flush_i (flush),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wr_entry),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count)
  );

  assign wb_valid = ~fifo_empty;
  assign wb_rd    = head.rd;
  assign wb_data  = head.data;
  assign wb_error = head.err;

  // Threshold DEPTH-1 leaves room for the op already in the align stage.
  assign stall_out = (count >= CNT_W'(DEPTH - 1));

  assign err_count = err_cnt_q;
  assign overflow  = overflow_q;

  always_comb begin
    s1_valid_d = valid_in & ~flush;
    s1_rd_d    = rd_in;
    overflow_d = overflow_q | drop;
    err_cnt_d  = err_cnt_q;
    if (err_clr)
      err_cnt_d = '0;
    else if (accept && error_in && !(&err_cnt_q))
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      s1_valid_q <= 1'b0;
      s1_rd_q    <= '0;
      err_cnt_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_rd_q    <= s1_rd_d;
      err_cnt_q  <= err_cnt_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_bmu_wb_queue.sv
// Self-checking bench for bmu_wb_queue: a queue-based reference model plus
// directed scenarios with literal expectations and a randomized phase.
module tb_bmu_wb_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        valid_in;
  logic [4:0]  rd_in;
  logic [31:0] result_in;
  logic        error_in;
  logic        flush;
  logic        err_clr;
  logic        stall_out;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_error;
  logic [2:0]  count;
  logic [7:0]  err_count;
  logic        overflow;

  bmu_wb_queue #(.DEPTH(4), .RD_W(5), .ERR_CNT_W(8)) dut (
    .clk       (clk),
    .rst_l     (rst_l),
    .valid_in  (valid_in),
    .rd_in     (rd_in),
    .result_in (result_in),
    .error_in  (error_in),
    .flush     (flush),
    .err_clr   (err_clr),
    .stall_out (stall_out),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .wb_error  (wb_error),
    .count     (count),
    .err_count (err_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
  } ent_t;

  ent_t       mq[$];
  bit         m_s1v;
  logic [4:0] m_s1rd;
  int         m_err;
  bit         m_ovf;
  bit         m_acc;
  ent_t       m_new;

  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      mq.delete();
      m_s1v  = 1'b0;
      m_s1rd = '0;
      m_err  = 0;
      m_ovf  = 1'b0;
    end else begin
      m_acc = 1'b0;
      if (flush) begin
        mq.delete();
      end else begin
        if (mq.size() != 0 && wb_ready) void'(mq.pop_front());
        if (m_s1v) begin
          if (mq.size() < DEPTH) begin
            m_new.rd   = m_s1rd;
            m_new.data = result_in;
            m_new.err  = error_in;
            mq.push_back(m_new);
            m_acc = 1'b1;
          end else begin
            m_ovf = 1'b1;
          end
        end
      end
      if (err_clr) m_err = 0;
      else if (m_acc && error_in && m_err < 255) m_err++;
      m_s1v  = valid_in && !flush;
      m_s1rd = rd_in;
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_wb_valid", {31'd0, wb_valid}, {31'd0, mq.size() != 0});
      chk("m_count", {29'd0, count}, mq.size());
      chk("m_stall", {31'd0, stall_out}, {31'd0, mq.size() >= DEPTH - 1});
      chk("m_wb_rd", {27'd0, wb_rd}, mq.size() != 0 ? {27'd0, mq[0].rd} : 32'd0);
      chk("m_wb_data", wb_data, mq.size() != 0 ? mq[0].data : 32'd0);
      chk("m_wb_error", {31'd0, wb_error}, mq.size() != 0 ? {31'd0, mq[0].err} : 32'd0);
      chk("m_err_count", {24'd0, err_count}, m_err);
      chk("m_overflow", {31'd0, overflow}, {31'd0, m_ovf});
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic [4:0] issued[$];
  logic [4:0] next_rd;

  task automatic fill4();
    wb_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      valid_in  = !stall_out;
      rd_in     = next_rd;
      result_in = $urandom;
      if (valid_in) begin
        issued.push_back(next_rd);
        next_rd++;
      end
      step();
    end
    valid_in = 1'b0;
  endtask

  task automatic drain();
    wb_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    wb_ready = 1'b0;
  endtask

  initial begin
    rst_l = 1'b0; valid_in = 1'b0; rd_in = '0; result_in = '0; error_in = 1'b0;
    flush = 1'b0; err_clr = 1'b0; wb_ready = 1'b0; next_rd = 5'd10;
    repeat (3) step();
    rst_l = 1'b1;
    cmp_en = 1'b1;
    step();
    chk("rst_count", {29'd0, count}, 0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 0);
    chk("rst_stall", {31'd0, stall_out}, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_err_count", {24'd0, err_count}, 0);
    chk("rst_overflow", {31'd0, overflow}, 0);

    // Single op: tag at T, result at T+1, visible at T+2.
    valid_in = 1'b1; rd_in = 5'd5;
    step();
    valid_in = 1'b0; rd_in = 5'd0; result_in = 32'h0000_0007;
    chk("lat_not_early", {31'd0, wb_valid}, 0);
    step();
    result_in = 32'hDEAD_BEEF;
    chk("lat_wb_valid", {31'd0, wb_valid}, 1);
    chk("lat_wb_rd", {27'd0, wb_rd}, 5);
    chk("lat_wb_data", wb_data, 32'h7);
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    chk("lat_drained", {29'd0, count}, 0);

    // Fill under stall discipline, then drain in order.
    issued.delete();
    fill4();
    chk("fill_count", {29'd0, count}, 4);
    chk("fill_stall", {31'd0, stall_out}, 1);
    chk("fill_no_ovf", {31'd0, overflow}, 0);
    chk("fill_issued", issued.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk("drain_order", {27'd0, wb_rd}, (k < issued.size()) ? {27'd0, issued[k]} : 32'hFFFF_FFFF);
      wb_ready = 1'b1;
      step();
      wb_ready = 1'b0;
    end
    chk("drain_empty", {29'd0, count}, 0);

    // Forced push while full.
    fill4();
    valid_in = 1'b1; rd_in = 5'd20;
    step();
    valid_in = 1'b0;
    step();
    chk("ovf_set", {31'd0, overflow}, 1);
    chk("ovf_count", {29'd0, count}, 4);
    valid_in = 1'b1; rd_in = 5'd21;
    step();
    valid_in = 1'b0; wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    chk("full_push_pop_count", {29'd0, count}, 4);
    chk("ovf_sticky", {31'd0, overflow}, 1);
    drain();
    chk("ovf_drained", {29'd0, count}, 0);

    // Three error pushes.
    error_in = 1'b1; result_in = 32'h7FFF_FFFF + 32'h1;
    valid_in = 1'b1;
    repeat (3) step();
    valid_in = 1'b0;
    repeat (2) step();
    error_in = 1'b0;
    chk("err_count3", {24'd0, err_count}, 3);
    chk("err_head", {31'd0, wb_error}, 1);
    chk("err_data", wb_data, 32'h8000_0000);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("err_cleared", {24'd0, err_count}, 0);

    // Asynchronous reset with 3 entries held.
    chk("pre_rst_count", {29'd0, count}, 3);
    @(negedge clk);
    #1 rst_l = 1'b0;
    #1;
    chk("arst_count", {29'd0, count}, 0);
    chk("arst_wb_valid", {31'd0, wb_valid}, 0);
    chk("arst_overflow", {31'd0, overflow}, 0);
    step();
    rst_l = 1'b1;
    step();

    // Flush with 2 held and one in flight, plus valid_in during flush.
    valid_in = 1'b1;
    rd_in = 5'd1; result_in = 32'h11; step();
    rd_in = 5'd2; result_in = 32'h22; step();
    rd_in = 5'd3; result_in = 32'h33; step();
    chk("pre_flush_count", {29'd0, count}, 2);
    flush = 1'b1; rd_in = 5'd4;
    step();
    flush = 1'b0; valid_in = 1'b0;
    chk("flush_count", {29'd0, count}, 0);
    chk("flush_wb_valid", {31'd0, wb_valid}, 0);
    repeat (2) step();
    chk("flush_no_ghost", {29'd0, count}, 0);

    // Saturation of err_count, then clear racing an error push.
    wb_ready = 1'b1; error_in = 1'b1; valid_in = 1'b1;
    repeat (270) step();
    valid_in = 1'b0;
    repeat (2) step();
    chk("err_sat", {24'd0, err_count}, 255);
    valid_in = 1'b1;
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0; valid_in = 1'b0;
    chk("clr_wins", {24'd0, err_count}, 0);
    error_in = 1'b0; wb_ready = 1'b0;
    drain();

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      valid_in  = !stall_out || ($urandom_range(15) == 0);
      valid_in  = valid_in && ($urandom_range(3) != 0);
      rd_in     = 5'($urandom);
      result_in = $urandom;
      error_in  = ($urandom_range(3) == 0);
      wb_ready  = ($urandom_range(2) != 0);
      flush     = ($urandom_range(31) == 0);
      err_clr   = ($urandom_range(31) == 0);
      step();
    end
    valid_in = 1'b0; flush = 1'b0; err_clr = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
